// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - byte stream in, instruction-memory IO write port out
interface instr_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_io_sel;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_io_sel, mem_en, mem_we, mem_addr, mem_din
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_io_sel, mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - loads a length-prefixed little-endian word stream into instruction memory
module instr_loader #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  instr_loader_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt;
  logic [31:0] len;
  logic [31:0] word_idx;
  logic [23:0] word_buf;
  logic [31:0] addr_q;
  logic [31:0] din_q;
  logic        err_q;
  logic        accept;
  logic        last_byte;
  logic        armable;
  logic [31:0] len_full;
  logic [31:0] word_next;

  assign bus.rx_ready   = (state == LEN) || (state == DATA);
  assign busy           = bus.rx_ready || (state == WRITE);
  assign bus.mem_io_sel = busy;
  assign bus.mem_en     = (state == WRITE);
  assign bus.mem_we     = (state == WRITE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_din    = din_q;
  assign done           = (state == DONE);
  assign err            = err_q;

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign armable   = (state == IDLE) || (state == DONE);
  // The top byte arrives on the same edge the length decision is taken.
  assign len_full  = {bus.rx_data, len[23:0]};
  assign word_next = word_idx + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = LEN;
      LEN: begin
        if (last_byte) begin
          if (len_full == 32'd0)              state_nxt = DONE;
          else if (len_full > DEPTH_WORDS)    state_nxt = DONE;
          else                                state_nxt = DATA;
        end
      end
      DATA:    if (last_byte) state_nxt = WRITE;
      WRITE:   state_nxt = (word_next == len) ? DONE : DATA;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      len      <= 32'd0;
      word_idx <= 32'd0;
      word_buf <= 24'd0;
      addr_q   <= BASE_ADDR;
      din_q    <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      if (armable && start) begin
        byte_cnt <= 2'd0;
        word_idx <= 32'd0;
        err_q    <= 1'b0;
      end
      if (accept) byte_cnt <= byte_cnt + 2'd1;
      if (accept && state == LEN) begin
        len[{byte_cnt, 3'b000} +: 8] <= bus.rx_data;
        if (last_byte && len_full > DEPTH_WORDS) err_q <= 1'b1;
      end
      if (accept && state == DATA) begin
        case (byte_cnt)
          2'd0: word_buf[7:0]   <= bus.rx_data;
          2'd1: word_buf[15:8]  <= bus.rx_data;
          2'd2: word_buf[23:16] <= bus.rx_data;
          default: begin
            // Memory-side registers only move when a complete word is ready.
            din_q  <= {bus.rx_data, word_buf};
            addr_q <= BASE_ADDR + {word_idx[29:0], 2'b00};
          end
        endcase
      end
      if (state == WRITE) word_idx <= word_next;
    end
  end

endmodule
